// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encoding, IR capture pattern, BYPASS opcode helper.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR   = 4'h0,
    EXIT1_DR   = 4'h1,
    SHIFT_DR   = 4'h2,
    PAUSE_DR   = 4'h3,
    SELECT_IR  = 4'h4,
    UPDATE_DR  = 4'h5,
    CAPTURE_DR = 4'h6,
    SELECT_DR  = 4'h7,
    EXIT2_IR   = 4'h8,
    EXIT1_IR   = 4'h9,
    SHIFT_IR   = 4'hA,
    PAUSE_IR   = 4'hB,
    RUN_IDLE   = 4'hC,
    UPDATE_IR  = 4'hD,
    CAPTURE_IR = 4'hE,
    TLR        = 4'hF
  } tap_state_e;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // All-ones opcode for an IR of the given width (width <= 32).
  function automatic logic [31:0] bypass_opcode(input int unsigned width);
    logic [32:0] ones;
    ones = (33'd1 << width) - 33'd1;
    return ones[31:0];
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine, advanced on posedge tck.
//   state      | meaning
//   TLR        | test-logic-reset, instruction forced to reset value
//   RUN_IDLE   | idle between scans
//   SELECT_x   | choose DR or IR column
//   CAPTURE_x  | parallel load of the selected shift register
//   SHIFT_x    | serial shift, tdi -> MSB, LSB -> tdo
//   EXIT1/2_x  | leave shift / pause
//   PAUSE_x    | hold shift contents
//   UPDATE_x   | commit shift contents
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e tap_state
);

  tap_state_e next_state;

  always_ff @(posedge tck or posedge trst) begin
    if (trst) tap_state <= TLR;
    else      tap_state <= next_state;
  end

  always_comb begin
    next_state = tap_state;
    case (tap_state)
      TLR:        next_state = tms ? TLR       : RUN_IDLE;
      RUN_IDLE:   next_state = tms ? SELECT_DR : RUN_IDLE;
      SELECT_DR:  next_state = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR: next_state = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:   next_state = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:   next_state = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:   next_state = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:   next_state = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:  next_state = tms ? SELECT_DR : RUN_IDLE;
      SELECT_IR:  next_state = tms ? TLR       : CAPTURE_IR;
      CAPTURE_IR: next_state = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:   next_state = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:   next_state = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:   next_state = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:   next_state = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:  next_state = tms ? SELECT_DR : RUN_IDLE;
      default:    next_state = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller: IR, BYPASS, optional IDCODE and NUM_DR user data registers.
// Build macro JTAG_TAP_IDCODE_EN adds the IDCODE register and makes it the reset instruction.
module jtag_tap_ctrl
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 8,
  parameter int          NUM_DR     = 2,
  parameter int          USER_BASE  = 8,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679
) (
  input  logic                       tck,
  input  logic                       trst,
  input  logic                       tms,
  input  logic                       tdi,
  input  logic                       read_not_write,
  output logic                       tdo,
  output logic                       tdo_en,
  input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture_data,
  output logic [NUM_DR*DR_WIDTH-1:0] dr_update_data,
  output logic [NUM_DR-1:0]          dr_update_vld,
  output logic [3:0]                 tap_state,
  output logic [IR_WIDTH-1:0]        ir_value
);

  localparam int UIDX_W = (NUM_DR > 1) ? $clog2(NUM_DR) : 1;
  localparam logic [31:0] BYPASS_WORD = bypass_opcode(IR_WIDTH);
  localparam logic [IR_WIDTH-1:0] BYPASS_OP = BYPASS_WORD[IR_WIDTH-1:0];
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(1);
`else
  // IDCODE_VAL contributes nothing here; the term only keeps the parameter referenced.
  localparam logic [IR_WIDTH-1:0] IR_RESET = BYPASS_OP | IR_WIDTH'(IDCODE_VAL & 32'h0);
`endif

  tap_state_e            state;
  logic [IR_WIDTH-1:0]   ir_sr;
  logic [IR_WIDTH-1:0]   ir_reg;
  logic                  bypass_sr;
  logic [DR_WIDTH-1:0]   user_sr;
  logic [DR_WIDTH-1:0]   capture_slice;
  logic                  is_user;
  logic [UIDX_W-1:0]     user_idx;
  logic                  shift_bit;
`ifdef JTAG_TAP_IDCODE_EN
  logic                  is_idcode;
  logic [31:0]           idcode_sr;
`endif

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tap_state (state)
  );

  assign tap_state = state;
  // TLR overrides the instruction combinationally so decode is correct on entry.
  assign ir_value  = (state == TLR) ? IR_RESET : ir_reg;

  always_comb begin
    is_user  = 1'b0;
    user_idx = '0;
`ifdef JTAG_TAP_IDCODE_EN
    is_idcode = (ir_value == IR_WIDTH'(1));
`endif
    if (ir_value != BYPASS_OP) begin
      for (int k = 0; k < NUM_DR; k++) begin
`ifdef JTAG_TAP_IDCODE_EN
        if (!is_idcode && ir_value == IR_WIDTH'(USER_BASE + k)) begin
`else
        if (ir_value == IR_WIDTH'(USER_BASE + k)) begin
`endif
          is_user  = 1'b1;
          user_idx = UIDX_W'(k);
        end
      end
    end
  end

  always_comb begin
    capture_slice = '0;
    for (int k = 0; k < NUM_DR; k++) begin
      if (user_idx == UIDX_W'(k)) capture_slice = dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_sr  <= '0;
      ir_reg <= IR_RESET;
    end else begin
      case (state)
        CAPTURE_IR: ir_sr <= IR_WIDTH'(IR_CAPTURE);
        SHIFT_IR:   ir_sr <= IR_WIDTH'({tdi, ir_sr} >> 1);
        default:    ;
      endcase
      if (state == TLR)            ir_reg <= IR_RESET;
      else if (state == UPDATE_IR) ir_reg <= ir_sr;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      bypass_sr <= 1'b0;
      user_sr   <= '0;
    end else if (state == CAPTURE_DR) begin
      bypass_sr <= 1'b0;
      if (is_user) user_sr <= capture_slice;
    end else if (state == SHIFT_DR) begin
      if (is_user) user_sr   <= DR_WIDTH'({tdi, user_sr} >> 1);
      else         bypass_sr <= tdi;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  always_ff @(posedge tck or posedge trst) begin
    if (trst)                                  idcode_sr <= '0;
    else if (state == CAPTURE_DR && is_idcode) idcode_sr <= IDCODE_VAL;
    else if (state == SHIFT_DR && is_idcode)   idcode_sr <= {tdi, idcode_sr[31:1]};
  end
`endif

  always_comb begin
    shift_bit = bypass_sr;
    if (state == SHIFT_IR)  shift_bit = ir_sr[0];
    else if (is_user)       shift_bit = user_sr[0];
`ifdef JTAG_TAP_IDCODE_EN
    else if (is_idcode)     shift_bit = idcode_sr[0];
`endif
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (state == SHIFT_DR || state == SHIFT_IR) begin
      tdo    <= shift_bit;
      tdo_en <= 1'b1;
    end else begin
      tdo_en <= 1'b0;
    end
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      dr_update_data <= '0;
      dr_update_vld  <= '0;
    end else begin
      dr_update_vld <= '0;
      if (state == UPDATE_DR && is_user && !read_not_write) begin
        for (int k = 0; k < NUM_DR; k++) begin
          if (user_idx == UIDX_W'(k)) begin
            dr_update_data[k*DR_WIDTH +: DR_WIDTH] <= user_sr;
            dr_update_vld[k]                       <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl; expected tdo streams are queued per scan and popped per negedge.
module tb_jtag_tap_ctrl;

  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        read_not_write = 1'b1;
  logic        tdo;
  logic        tdo_en;
  logic [15:0] dr_capture_data = 16'h0;
  logic [15:0] dr_update_data;
  logic [1:0]  dr_update_vld;
  logic [3:0]  tap_state;
  logic [3:0]  ir_value;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q[$];

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] IR_RST = 4'h1;
`else
  localparam logic [3:0] IR_RST = 4'hF;
`endif

  jtag_tap_ctrl dut (
    .tck             (tck),
    .trst            (trst),
    .tms             (tms),
    .tdi             (tdi),
    .read_not_write  (read_not_write),
    .tdo             (tdo),
    .tdo_en          (tdo_en),
    .dr_capture_data (dr_capture_data),
    .dr_update_data  (dr_update_data),
    .dr_update_vld   (dr_update_vld),
    .tap_state       (tap_state),
    .ir_value        (ir_value)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  // From RUN_IDLE: full scan of n bits, optional pause after pause_at bits, ends in RUN_IDLE.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                      input int len, input logic [63:0] cap, input int pause_at);
    bit e;
    bit last;
    bit brk;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i < len) exp_q.push_back(cap[i]);
      else         exp_q.push_back(din[i-len]);
    end
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (tdo_en !== 1'b1 || tdo !== e) begin
        n_err++;
        $display("FAIL scan_bit ir=%0d i=%0d: tdo=%b tdo_en=%b, required tdo=%b tdo_en=1",
                 is_ir, i, tdo, tdo_en, e);
      end
      last = (i == n - 1);
      brk  = (i == pause_at - 1) && !last;
      step(last || brk, din[i]);
      if (brk) begin
        step(1'b0, 1'b0);
        n_cmp++;
        if (tdo_en !== 1'b0 || tap_state !== (is_ir ? 4'hB : 4'h3)) begin
          n_err++;
          $display("FAIL pause_hold: tdo_en=%b state=%h, required tdo_en=0 state=%h",
                   tdo_en, tap_state, is_ir ? 4'hB : 4'h3);
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end
    end
    n_cmp++;
    if (tdo_en !== 1'b0 || tap_state !== (is_ir ? 4'h9 : 4'h1)) begin
      n_err++;
      $display("FAIL scan_exit: tdo_en=%b state=%h, required tdo_en=0 state=%h",
               tdo_en, tap_state, is_ir ? 4'h9 : 4'h1);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    trst = 1'b1;
    #2;
    n_cmp++;
    if (tap_state !== 4'hF || ir_value !== IR_RST || tdo !== 1'b0 || tdo_en !== 1'b0 ||
        dr_update_data !== 16'h0 || dr_update_vld !== 2'b00) begin
      n_err++;
      $display("FAIL reset: state=%h ir=%h tdo=%b en=%b upd=%h vld=%b, required F %h 0 0 0000 00",
               tap_state, ir_value, tdo, tdo_en, dr_update_data, dr_update_vld, IR_RST);
    end
    @(negedge tck);
    #1;
    trst = 1'b0;
    step(1'b1, 1'b0);
    n_cmp++;
    if (tap_state !== 4'hF) begin
      n_err++;
      $display("FAIL tlr_hold: state=%h, required F", tap_state);
    end
  endtask

  task automatic test_default_dr();
    logic [63:0] din;
    din = {32'h0, $urandom()};
    step(1'b0, 1'b0);
`ifdef JTAG_TAP_IDCODE_EN
    scan(1'b0, 32, din, 32, 64'h1234_5679, -1);
`else
    scan(1'b0, 32, din, 1, 64'h0, -1);
`endif
  endtask

  task automatic test_tlr_from_shift();
    read_not_write = 1'b1;
    scan(1'b1, 4, 64'h9, 4, 64'h1, -1);
    n_cmp++;
    if (ir_value !== 4'h9) begin
      n_err++;
      $display("FAIL ir_load9: ir=%h, required 9", ir_value);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_cmp++;
    if (tap_state !== 4'hF || ir_value !== IR_RST) begin
      n_err++;
      $display("FAIL tms_reset: state=%h ir=%h, required F %h", tap_state, ir_value, IR_RST);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    scan(1'b1, 4, 64'hF, 4, 64'h1, -1);
    n_cmp++;
    if (ir_value !== 4'hF) begin
      n_err++;
      $display("FAIL ir_loadF: ir=%h, required F", ir_value);
    end
    scan(1'b0, 8, 64'hA5, 1, 64'h0, -1);
  endtask

  task automatic test_user_write();
    read_not_write  = 1'b0;
    dr_capture_data = {8'h3C, 8'h77};
    scan(1'b1, 4, 64'h9, 4, 64'h1, -1);
    scan(1'b0, 8, 64'hC3, 8, 64'h3C, -1);
    n_cmp++;
    if (dr_update_data !== 16'hC300 || dr_update_vld !== 2'b10) begin
      n_err++;
      $display("FAIL user_write: upd=%h vld=%b, required C300 10", dr_update_data, dr_update_vld);
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (dr_update_vld !== 2'b00) begin
      n_err++;
      $display("FAIL vld_pulse_width: vld=%b, required 00", dr_update_vld);
    end
  endtask

  task automatic test_user_read();
    read_not_write  = 1'b1;
    dr_capture_data = {8'h5A, 8'h77};
    scan(1'b0, 8, 64'h11, 8, 64'h5A, -1);
    n_cmp++;
    if (dr_update_data !== 16'hC300 || dr_update_vld !== 2'b00) begin
      n_err++;
      $display("FAIL user_read: upd=%h vld=%b, required C300 00", dr_update_data, dr_update_vld);
    end
  endtask

  task automatic test_pause();
    read_not_write  = 1'b0;
    dr_capture_data = {8'h5A, 8'h96};
    scan(1'b1, 4, 64'h8, 4, 64'h1, -1);
    scan(1'b0, 8, 64'h4B, 8, 64'h96, 3);
    n_cmp++;
    if (dr_update_data !== 16'hC34B || dr_update_vld !== 2'b01) begin
      n_err++;
      $display("FAIL pause_write: upd=%h vld=%b, required C34B 01", dr_update_data, dr_update_vld);
    end
  endtask

  task automatic test_long_shift();
    logic [63:0] din;
    read_not_write = 1'b1;
    din = {48'h0, 16'($urandom())};
    scan(1'b0, 16, din, 8, 64'h96, -1);
  endtask

  task automatic test_trst_mid_shift();
    read_not_write = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    n_cmp++;
    if (tdo_en !== 1'b1 || tap_state !== 4'h2) begin
      n_err++;
      $display("FAIL pre_abort: en=%b state=%h, required 1 2", tdo_en, tap_state);
    end
    #1;
    trst = 1'b1;
    #1;
    n_cmp++;
    if (tap_state !== 4'hF || dr_update_data !== 16'h0 || tdo_en !== 1'b0 ||
        dr_update_vld !== 2'b00 || ir_value !== IR_RST) begin
      n_err++;
      $display("FAIL trst_abort: state=%h upd=%h en=%b vld=%b ir=%h, required F 0000 0 00 %h",
               tap_state, dr_update_data, tdo_en, dr_update_vld, ir_value, IR_RST);
    end
    @(negedge tck);
    #1;
    trst = 1'b0;
    step(1'b0, 1'b0);
    n_cmp++;
    if (dr_update_vld !== 2'b00 || tap_state !== 4'hC) begin
      n_err++;
      $display("FAIL post_abort: vld=%b state=%h, required 00 C", dr_update_vld, tap_state);
    end
  endtask

  initial begin
    @(negedge tck);
    #1;
    test_reset();
    test_default_dr();
    test_tlr_from_shift();
    test_bypass();
    test_user_write();
    test_user_read();
    test_pause();
    test_long_shift();
    test_trst_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
